// File: rtl/reg_scoreboard_if.sv
// Decode / writeback / squash bundle for the register scoreboard.
// master = pipeline control that drives the events, slave = reg_scoreboard.
interface reg_scoreboard_if;
    logic        d_valid;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic        w_valid;
    logic [3:0]  w_dstE;
    logic [3:0]  w_dstM;
    logic        k_valid;
    logic [3:0]  k_dstE;
    logic [3:0]  k_dstM;
    logic        d_stall;
    logic [14:0] pend_mask;
    logic [3:0]  inflight;
    logic        err_underflow;

    modport master (
        output d_valid, d_srcA, d_srcB, d_dstE, d_dstM,
        output w_valid, w_dstE, w_dstM,
        output k_valid, k_dstE, k_dstM,
        input  d_stall, pend_mask, inflight, err_underflow
    );

    modport slave (
        input  d_valid, d_srcA, d_srcB, d_dstE, d_dstM,
        input  w_valid, w_dstE, w_dstM,
        input  k_valid, k_dstE, k_dstM,
        output d_stall, pend_mask, inflight, err_underflow
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Decode-stage hazard controller for the Y86-64 register file.
// Keeps a pending-write counter per architectural register (0-14, 4'hF = none),
// stalls decode on RAW hazards or counter overflow, and releases reservations
// on writeback or squash.
// Optional build macro: REG_SCOREBOARD_BYPASS_EN -- a source whose counter is
// drained to zero by this cycle's releases is not hazarded.
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_scoreboard_if.slave bus
);
    localparam int NREG    = 15;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [NREG-1:0]  pend_mask_q, pend_mask_d;
    logic [3:0]       inflight_q, inflight_d;
    logic             err_underflow_q, err_underflow_d;

    logic [2:0]  inc_req [NREG];  // increments requested by decode (0..2)
    logic [2:0]  dec     [NREG];  // decrements from writeback + squash (0..4)
    logic [15:0] blocked;         // bit 15 stands for "no register", never blocks
    logic        overflow;
    logic        d_stall;
    logic        issue;

    // Per-register request decode, overflow check and source blocking.
    always_comb begin
        overflow = 1'b0;
        blocked  = '0;
        for (int r = 0; r < NREG; r++) begin
            // r never equals 4'hF, so "no register" falls out of the compare.
            inc_req[r] = {2'b0, bus.d_valid && (bus.d_dstE == 4'(r))}
                       + {2'b0, bus.d_valid && (bus.d_dstM == 4'(r))};
            dec[r]     = {2'b0, bus.w_valid && (bus.w_dstE == 4'(r))}
                       + {2'b0, bus.w_valid && (bus.w_dstM == 4'(r))}
                       + {2'b0, bus.k_valid && (bus.k_dstE == 4'(r))}
                       + {2'b0, bus.k_valid && (bus.k_dstM == 4'(r))};
            // Overflow ignores same-cycle releases on purpose.
            if (int'(cnt_q[r]) + int'(inc_req[r]) > CNT_MAX)
                overflow = 1'b1;
`ifdef REG_SCOREBOARD_BYPASS_EN
            // Register file writes on negedge, so a drained counter is safe to read.
            blocked[r] = int'(cnt_q[r]) > int'(dec[r]);
`else
            blocked[r] = cnt_q[r] != '0;
`endif
        end
    end

    // Stall decision is same-cycle; a bubble never stalls.
    always_comb begin
        d_stall = bus.d_valid & (blocked[bus.d_srcA] | blocked[bus.d_srcB] | overflow);
        issue   = bus.d_valid & ~d_stall;
    end

    // Net per-register delta, underflow clamp and aggregate in-flight count.
    always_comb begin
        int net;
        int tot;
        int infl;
        net             = 0;
        tot             = 0;
        infl            = 0;
        err_underflow_d = err_underflow_q;
        for (int r = 0; r < NREG; r++) begin
            net = int'(cnt_q[r]) + (issue ? int'(inc_req[r]) : 0) - int'(dec[r]);
            tot = tot + (issue ? int'(inc_req[r]) : 0) - int'(dec[r]);
            if (net < 0) begin
                err_underflow_d = 1'b1;
                net             = 0;
            end
            cnt_d[r]       = CNT_W'(net);
            pend_mask_d[r] = net != 0;
        end
        infl = int'(inflight_q) + tot;
        if (infl < 0)
            infl = 0;
        else if (infl > 15)
            infl = 15;
        inflight_d = 4'(infl);
    end

    // State registers; reset drops every reservation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++)
                cnt_q[r] <= '0;
            pend_mask_q     <= '0;
            inflight_q      <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++)
                cnt_q[r] <= cnt_d[r];
            pend_mask_q     <= pend_mask_d;
            inflight_q      <= inflight_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign bus.d_stall       = d_stall;
    assign bus.pend_mask     = pend_mask_q;
    assign bus.inflight      = inflight_q;
    assign bus.err_underflow = err_underflow_q;
endmodule
